mp3_data_port: RTL and testbench

Request-side driver for the 32-set x 256-bit byte-masked data-array SRAM macro used by the cache. It converts cache-controller requests into SRAM control signals: word reads, byte-masked 32-bit word writes, and full or partial 256-bit line writes. It returns read data with one-cycle latency under a valid/ready handshake. After reset it zero-initialises all 32 sets before accepting any request.

---
 rtl/mp3_data_port_pkg.sv | 27 ++
 rtl/mp3_wmask_expand.sv | 18 +
 rtl/mp3_data_port.sv | 158 +++++++++++++++
 tb/tb_mp3_data_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_data_port_pkg.sv
// Shared types and geometry for the cache data-array port driver.
package mp3_data_port_pkg;

  localparam int unsigned NUM_SETS   = 32;
  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned IDX_LSB    = 5;
  localparam int unsigned IDX_MSB    = 9;
  localparam int unsigned WSEL_LSB   = 2;
  localparam int unsigned IDX_W      = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned WSEL_W     = IDX_LSB - WSEL_LSB;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned WORD_W     = WORD_BYTES * 8;

  // Encoding 3 is reserved and handled as a read.
  typedef enum logic [1:0] {
    REQ_READ       = 2'd0,
    REQ_WRITE_WORD = 2'd1,
    REQ_WRITE_LINE = 2'd2
  } req_kind_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mp3_wmask_expand.sv
// Places a byte-masked 32-bit word into its lane of a 256-bit line write.
module mp3_wmask_expand
  import mp3_data_port_pkg::*;
(
  input  logic [WSEL_W-1:0]     word_sel_i,
  input  logic [WORD_BYTES-1:0] mask_i,
  input  logic [WORD_W-1:0]     data_i,
  output logic [LINE_BYTES-1:0] wmask_o,
  output logic [LINE_W-1:0]     din_o
);

  // Byte mask shifted to the selected word; data replicated into every lane.
  always_comb begin
    wmask_o = LINE_BYTES'(mask_i) << {word_sel_i, 2'b00};
    din_o   = {(LINE_BYTES / WORD_BYTES){data_i}};
  end

endmodule

// File: rtl/mp3_data_port.sv
// Request-side driver for the 32-set x 256-bit byte-masked data SRAM.
// Zero-fills every set after reset, then serves reads and writes with a
// one-cycle response under valid/ready.
module mp3_data_port
  import mp3_data_port_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_kind,
  input  logic [31:0]           req_addr,
  input  logic [WORD_W-1:0]     req_wdata,
  input  logic [WORD_BYTES-1:0] req_wmask,
  input  logic [LINE_W-1:0]     req_line,
  input  logic [LINE_BYTES-1:0] req_line_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WORD_W-1:0]     resp_rdata,
  output logic [LINE_W-1:0]     resp_line,
  output logic                  resp_was_write,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [IDX_W-1:0]      sram_addr,
  output logic [LINE_BYTES-1:0] sram_wmask,
  output logic [LINE_W-1:0]     sram_din,
  input  logic [LINE_W-1:0]     sram_dout
);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     init_cnt_q, init_cnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 was_write_q, was_write_d;
  logic [WSEL_W-1:0]    word_sel_q, word_sel_d;

  req_kind_t            kind;
  logic                 is_write;
  logic                 stall;
  logic                 fire;
  logic [IDX_W-1:0]     req_idx;
  logic [WSEL_W-1:0]    req_wsel;
  logic [LINE_BYTES-1:0] word_wmask;
  logic [LINE_W-1:0]    word_din;
  logic                 unused_addr;

  assign kind        = req_kind_t'(req_kind);
  assign is_write    = (kind == REQ_WRITE_WORD) || (kind == REQ_WRITE_LINE);
  assign req_idx     = req_addr[IDX_MSB:IDX_LSB];
  assign req_wsel    = req_addr[IDX_LSB-1:WSEL_LSB];
  assign unused_addr = ^{req_addr[31:IDX_MSB+1], req_addr[WSEL_LSB-1:0]};

  // A held response blocks new requests; only RUN can accept.
  assign stall = resp_valid_q && !resp_ready;
  assign fire  = (state_q == RUN) && req_valid && !stall;

  mp3_wmask_expand u_wmask_expand (
    .word_sel_i (req_wsel),
    .mask_i     (req_wmask),
    .data_i     (req_wdata),
    .wmask_o    (word_wmask),
    .din_o      (word_din)
  );

  // FSM state register and init sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: sweep every set once, then run forever.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == IDX_W'(NUM_SETS - 1)) begin
        state_d = RUN;
      end
    end
  end

  // Outputs: zero-fill writes during INIT, request-driven SRAM access in RUN.
  always_comb begin
    req_ready  = 1'b0;
    sram_csb   = 1'b1;
    sram_web   = 1'b1;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_din   = '0;
    unique case (state_q)
      INIT: begin
        sram_csb   = 1'b0;
        sram_web   = 1'b0;
        sram_addr  = init_cnt_q;
        sram_wmask = '1;
      end
      RUN: begin
        req_ready = !stall;
        if (fire) begin
          sram_csb  = 1'b0;
          sram_addr = req_idx;
          case (kind)
            REQ_WRITE_WORD: begin
              sram_web   = 1'b0;
              sram_wmask = word_wmask;
              sram_din   = word_din;
            end
            REQ_WRITE_LINE: begin
              sram_web   = 1'b0;
              sram_wmask = req_line_wmask;
              sram_din   = req_line;
            end
            default: sram_web = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Response next state: capture on accept, hold while stalled.
  always_comb begin
    resp_valid_d = fire || stall;
    was_write_d  = was_write_q;
    word_sel_d   = word_sel_q;
    if (fire) begin
      was_write_d = is_write;
      word_sel_d  = req_wsel;
    end
  end

  // Response registers; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      was_write_q  <= 1'b0;
      word_sel_q   <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      was_write_q  <= was_write_d;
      word_sel_q   <= word_sel_d;
    end
  end

  // Read data comes straight from the SRAM, which holds dout while deselected.
  always_comb begin
    resp_valid     = resp_valid_q;
    resp_was_write = was_write_q;
    resp_line      = was_write_q ? '0 : sram_dout;
    resp_rdata     = was_write_q ? '0 : sram_dout[{word_sel_q, 5'b00000} +: WORD_W];
  end

endmodule

// File: tb/tb_mp3_data_port.sv
// Directed bench for mp3_data_port with a behavioural byte-masked SRAM load.
module tb_mp3_data_port;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_kind;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_wmask;
  logic [255:0] req_line;
  logic [31:0]  req_line_wmask;
  logic         resp_valid;
  logic         resp_ready;
  logic [31:0]  resp_rdata;
  logic [255:0] resp_line;
  logic         resp_was_write;
  logic         sram_csb;
  logic         sram_web;
  logic [4:0]   sram_addr;
  logic [31:0]  sram_wmask;
  logic [255:0] sram_din;
  logic [255:0] sram_dout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mp3_data_port dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_kind       (req_kind),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .req_line       (req_line),
    .req_line_wmask (req_line_wmask),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_line      (resp_line),
    .resp_was_write (resp_was_write),
    .sram_csb       (sram_csb),
    .sram_web       (sram_web),
    .sram_addr      (sram_addr),
    .sram_wmask     (sram_wmask),
    .sram_din       (sram_din),
    .sram_dout      (sram_dout)
  );

  // SRAM model: inputs registered at posedge, array/dout updated at negedge.
  logic [255:0] mem [32];
  logic         csb_r, web_r;
  logic [4:0]   addr_r;
  logic [31:0]  wm_r;
  logic [255:0] din_r;

  always @(posedge clk) begin
    csb_r  <= sram_csb;
    web_r  <= sram_web;
    addr_r <= sram_addr;
    wm_r   <= sram_wmask;
    din_r  <= sram_din;
  end

  always @(negedge clk) begin
    if (csb_r === 1'b0) begin
      if (web_r === 1'b0) begin
        for (int b = 0; b < 32; b++) begin
          if (wm_r[b]) mem[addr_r][8*b +: 8] <= din_r[8*b +: 8];
        end
      end else begin
        sram_dout <= mem[addr_r];
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm,
                       input logic [255:0] ln, input logic [31:0] lm);
    req_valid      = v;
    req_kind       = k;
    req_addr       = a;
    req_wdata      = wd;
    req_wmask      = wm;
    req_line       = ln;
    req_line_wmask = lm;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0, 256'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(1'b1, 2'd0, a, 32'h0, 4'h0, 256'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
    #1;
  endtask

  // Checks 32 zero-fill cycles starting in the current cycle; ends in the first RUN cycle.
  task automatic check_init();
    for (int j = 0; j < 32; j++) begin
      #1;
      if (j == 0) check("reset_resp", {resp_valid, resp_was_write}, 2'b00);
      check("init_ctrl", {sram_csb, sram_web, req_ready, sram_addr, sram_wmask},
            {1'b0, 1'b0, 1'b0, 5'(j), 32'hFFFFFFFF});
      check("init_din", sram_din, 256'h0);
      next_cycle();
    end
  endtask

  logic [255:0] line4;

  initial begin
    for (int k = 0; k < 8; k++) line4[32*k +: 32] = 32'(k);

    // 1: reset, init sweep, then every set reads back 0.
    rst        = 1'b1;
    resp_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rd(32'h0);
    check_init();
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) next_cycle();
      if (i < 32) rd(32'(i) << 5);
      else idle();
      #1;
      check("run_ready", req_ready, 1'b1);
      if (i < 32) check("rd_ctrl", {sram_csb, sram_web, sram_addr}, {1'b0, 1'b1, 5'(i)});
      to_sample();
      if (i > 0) begin
        check("zero_valid", {resp_valid, resp_was_write}, 2'b10);
        check("zero_line", resp_line, 256'h0);
      end
    end

    // 2: word write to 0x128 then immediate read.
    next_cycle();
    drive(1'b1, 2'd1, 32'h128, 32'hDEADBEEF, 4'hF, 256'h0, 32'h0);
    #1;
    check("ww_ctrl", {sram_csb, sram_web, sram_addr, sram_wmask},
          {1'b0, 1'b0, 5'd9, 32'h00000F00});
    check("ww_din", sram_din, {8{32'hDEADBEEF}});
    next_cycle();
    rd(32'h128);
    to_sample();
    check("ww_ack", {resp_valid, resp_was_write, resp_rdata}, {1'b1, 1'b1, 32'h0});
    check("ww_ack_line", resp_line, 256'h0);
    next_cycle();
    idle();
    to_sample();
    check("raw_rdata", {resp_valid, resp_was_write, resp_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
    check("raw_line", resp_line, {128'h0, 32'hDEADBEEF, 64'h0});

    // 3: partial word write, then two reads.
    next_cycle();
    drive(1'b1, 2'd1, 32'h12C, 32'h11223344, 4'h3, 256'h0, 32'h0);
    #1;
    check("pw_ctrl", {sram_web, sram_addr, sram_wmask}, {1'b0, 5'd9, 32'h00003000});
    next_cycle();
    idle();
    next_cycle();
    rd(32'h12C);
    next_cycle();
    rd(32'h128);
    to_sample();
    check("pw_rdata", resp_rdata, 32'h00003344);
    next_cycle();
    idle();
    to_sample();
    check("pw_keep", resp_rdata, 32'hDEADBEEF);
    check("pw_line", resp_line, {96'h0, 32'h00003344, 32'hDEADBEEF, 64'h0});

    // 4: line write to set 4 then 8 back-to-back word reads.
    next_cycle();
    drive(1'b1, 2'd2, 32'h80, 32'h0, 4'h0, line4, 32'hFFFFFFFF);
    #1;
    check("wl_ctrl", {sram_csb, sram_web, sram_addr, sram_wmask},
          {1'b0, 1'b0, 5'd4, 32'hFFFFFFFF});
    check("wl_din", sram_din, line4);
    for (int i = 0; i <= 8; i++) begin
      next_cycle();
      if (i < 8) rd(32'h80 + 32'(4 * i));
      else idle();
      #1;
      if (i < 8) check("b2b_ready", req_ready, 1'b1);
      to_sample();
      if (i == 0) check("wl_ack", {resp_valid, resp_was_write}, 2'b11);
      else check("b2b_rdata", {resp_valid, resp_rdata}, {1'b1, 32'(i - 1)});
    end

    // 5: stall a read response for 3 cycles, then consume it.
    next_cycle();
    rd(32'h128);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      resp_ready = 1'b0;
      rd(32'h84);
      #1;
      check("stall_ctrl", {req_ready, sram_csb}, 2'b01);
      to_sample();
      check("stall_resp", {resp_valid, resp_was_write, resp_rdata},
            {1'b1, 1'b0, 32'hDEADBEEF});
    end
    next_cycle();
    resp_ready = 1'b1;
    #1;
    check("unstall_ctrl", {req_ready, sram_csb, sram_addr}, {1'b1, 1'b0, 5'd4});
    to_sample();
    check("unstall_resp", {resp_valid, resp_rdata}, {1'b1, 32'hDEADBEEF});

    // 6: reset in the middle of a stall.
    next_cycle();
    resp_ready = 1'b0;
    idle();
    to_sample();
    check("stall2_resp", {resp_valid, resp_rdata}, {1'b1, 32'h1});
    next_cycle();
    rst = 1'b1;
    to_sample();
    check("pre_rst_resp", resp_valid, 1'b1);
    next_cycle();
    rst        = 1'b0;
    resp_ready = 1'b1;
    rd(32'h128);
    check_init();
    check("post_init_ready", req_ready, 1'b1);
    next_cycle();
    rd(32'h84);
    to_sample();
    check("clr_128", {resp_valid, resp_rdata}, {1'b1, 32'h0});
    check("clr_128_line", resp_line, 256'h0);
    next_cycle();
    idle();
    to_sample();
    check("clr_84", {resp_valid, resp_rdata}, {1'b1, 32'h0});
    check("clr_84_line", resp_line, 256'h0);
    next_cycle();
    to_sample();
    check("idle_drop", resp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
